jesd_rx_link_ctrl: RTL and testbench

Link-level controller for the JESD204B receiver data path. Sequences the data path's CGS reset, IFS reset and buffer release from its status outputs. Generates the SYNC~ handshake toward the transmitter and a SYSREF-aligned local multiframe clock (LMFC). Supervises the link and forces a resynchronisation on ILAS timeout or excessive character errors.

---
 rtl/jesd_rx_pkg.sv | 61 ++++++
 rtl/jesd_rx_link_ctrl_lmfc_gen.sv | 47 ++++
 rtl/jesd_rx_link_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_jesd_rx_link_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd_rx_pkg.sv
// -----------------------------------------------------------------------------
// jesd_rx_pkg
// Shared types for the JESD204B receive link controller.
//   STATE_W         : width of the link state encoding
//   rx_link_state_e : link controller states (encodings are visible on state_o)
//   rx_link_ctrl_t  : the data-path control and status bits decoded from a state
//   decode_ctrl()   : Moore decode from state to rx_link_ctrl_t
// -----------------------------------------------------------------------------
package jesd_rx_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CGS     = 3'd1,
        ST_ILAS    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DATA    = 3'd4,
        ST_RESYNC  = 3'd5
    } rx_link_state_e;

    typedef struct packed {
        logic cgs_reset;
        logic ifs_reset;
        logic release_n;
        logic sync_n;
        logic link_up;
    } rx_link_ctrl_t;

    // IDLE and RESYNC share the fully-reset pattern, which is also the
    // fallback for the unused encodings.
    function automatic rx_link_ctrl_t decode_ctrl(rx_link_state_e st);
        rx_link_ctrl_t c;
        c.cgs_reset = 1'b1;
        c.ifs_reset = 1'b1;
        c.release_n = 1'b1;
        c.sync_n    = 1'b0;
        c.link_up   = 1'b0;
        case (st)
            ST_CGS: begin
                c.cgs_reset = 1'b0;
            end
            ST_ILAS, ST_RELEASE: begin
                c.cgs_reset = 1'b0;
                c.ifs_reset = 1'b0;
                c.sync_n    = 1'b1;
            end
            ST_DATA: begin
                c.cgs_reset = 1'b0;
                c.ifs_reset = 1'b0;
                c.sync_n    = 1'b1;
                c.release_n = 1'b0;
                c.link_up   = 1'b1;
            end
            default: begin
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/jesd_rx_link_ctrl_lmfc_gen.sv
// -----------------------------------------------------------------------------
// lmfc_gen
// SYSREF-aligned local multiframe clock. A counter runs 0..MF_CYCLES-1 and
// wraps; every SYSREF rising edge forces it to 0 on the following cycle.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   sysref_i  : SYSREF, already synchronous to clk_i
//   lmfc_o    : high while the counter is 0 (multiframe boundary)
// -----------------------------------------------------------------------------
module lmfc_gen #(
    parameter int MF_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sysref_i,
    output logic lmfc_o
);

    localparam int CNT_W = $clog2(MF_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MF_CYCLES - 1);

    logic [CNT_W-1:0] lmfc_cnt;
    logic             sysref_q;
    logic             sysref_edge;

    // Only the rising edge re-aligns, so a SYSREF held high acts once.
    assign sysref_edge = sysref_i & ~sysref_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sysref_q <= 1'b0;
            lmfc_cnt <= '0;
        end else begin
            sysref_q <= sysref_i;
            if (sysref_edge || (lmfc_cnt == CNT_LAST)) begin
                lmfc_cnt <= '0;
            end else begin
                lmfc_cnt <= lmfc_cnt + 1'b1;
            end
        end
    end

    assign lmfc_o = (lmfc_cnt == '0);

endmodule

// File: rtl/jesd_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// jesd_rx_link_ctrl
// Link-level controller for the JESD204B receive data path: sequences CGS
// reset, IFS reset and buffer release, drives SYNC~, generates the LMFC and
// forces resynchronisation on ILAS timeout or excessive character errors.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   enable_i            : link enable; low returns the link to IDLE
//   sysref_i            : SYSREF, synchronous to clk_i
//   cgs_detected_i      : data path reports CGS achieved
//   buffer_ready_ni     : low once the data path has seen the ILAS end
//   char_err_i          : character error on any octet this cycle
//   cgs_reset_o         : data path CGS reset
//   ifs_reset_o         : data path IFS reset
//   buffer_release_no   : data path elastic buffer release, active-low
//   sync_no             : SYNC~ toward the transmitter, active-low
//   lmfc_o              : LMFC boundary pulse
//   link_up_o           : high in DATA
//   timeout_o           : sticky ILAS timeout flag
//   state_o             : current state encoding
//   resync_cnt_o        : saturating count of resynchronisations
// -----------------------------------------------------------------------------
module jesd_rx_link_ctrl
    import jesd_rx_pkg::*;
#(
    parameter int MF_CYCLES       = 8,
    parameter int RBD             = 0,
    parameter int ILAS_TIMEOUT_MF = 8,
    parameter int ERR_THRESH      = 4,
    parameter int CNT_W           = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               sysref_i,
    input  logic               cgs_detected_i,
    input  logic               buffer_ready_ni,
    input  logic               char_err_i,
    output logic               cgs_reset_o,
    output logic               ifs_reset_o,
    output logic               buffer_release_no,
    output logic               sync_no,
    output logic               lmfc_o,
    output logic               link_up_o,
    output logic               timeout_o,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   resync_cnt_o
);

    localparam int ILAS_W = $clog2(ILAS_TIMEOUT_MF + 1);
    localparam int ERR_W  = $clog2(ERR_THRESH + 1);
    localparam int RBD_W  = $clog2(MF_CYCLES);

    localparam logic [ILAS_W-1:0] ILAS_LAST = ILAS_W'(ILAS_TIMEOUT_MF - 1);
    localparam logic [ERR_W:0]    ERR_LIMIT = (ERR_W + 1)'(ERR_THRESH);
    localparam logic [RBD_W-1:0]  RBD_LAST  = RBD_W'(RBD);

    rx_link_state_e    state;
    rx_link_state_e    next_state;
    rx_link_ctrl_t     ctrl;
    logic              lmfc;
    logic [ILAS_W-1:0] ilas_mf_cnt;
    logic [ERR_W-1:0]  err_cnt;
    logic [ERR_W:0]    err_sum;
    logic              err_hit;
    logic [RBD_W-1:0]  rbd_cnt;
    logic              rbd_done;
    logic              timeout_q;
    logic [CNT_W-1:0]  resync_cnt;

    lmfc_gen #(
        .MF_CYCLES (MF_CYCLES)
    ) u_lmfc_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sysref_i (sysref_i),
        .lmfc_o   (lmfc)
    );

    // One bit of headroom so the sum can reach ERR_THRESH at any width.
    assign err_sum = {1'b0, err_cnt} + {{ERR_W{1'b0}}, char_err_i};
    assign err_hit = (err_sum >= ERR_LIMIT);

    // rbd_cnt==0 means no boundary seen yet in RELEASE; after the boundary it
    // counts 1..RBD, so RBD=0 leaves on the boundary cycle itself.
    assign rbd_done = (rbd_cnt == '0) ? (lmfc && (RBD == 0)) : (rbd_cnt == RBD_LAST);

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        if (!enable_i) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_CGS;
                end
                ST_CGS: begin
                    // SYNC~ may only be released on a multiframe boundary.
                    if (cgs_detected_i && lmfc) next_state = ST_ILAS;
                end
                ST_ILAS: begin
                    if (!buffer_ready_ni) begin
                        next_state = ST_RELEASE;
                    end else if (lmfc && (ilas_mf_cnt == ILAS_LAST)) begin
                        next_state = ST_RESYNC;
                    end
                end
                ST_RELEASE: begin
                    if (rbd_done) next_state = ST_DATA;
                end
                ST_DATA: begin
                    if (err_hit) next_state = ST_RESYNC;
                end
                ST_RESYNC: begin
                    next_state = ST_CGS;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ILAS multiframe counter: held at zero outside ILAS, so it is clear on entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ilas_mf_cnt <= '0;
        end else if (state != ST_ILAS) begin
            ilas_mf_cnt <= '0;
        end else if (lmfc) begin
            ilas_mf_cnt <= ilas_mf_cnt + 1'b1;
        end
    end

    // Per-multiframe error counter: a boundary restarts it with this cycle's
    // error. It only carries a value while DATA persists, so it is clear on entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else if ((state != ST_DATA) || (next_state != ST_DATA)) begin
            err_cnt <= '0;
        end else if (lmfc) begin
            err_cnt <= {{(ERR_W-1){1'b0}}, char_err_i};
        end else begin
            err_cnt <= err_sum[ERR_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rbd_cnt <= '0;
        end else if (state != ST_RELEASE) begin
            rbd_cnt <= '0;
        end else if (rbd_cnt == '0) begin
            if (lmfc) rbd_cnt <= RBD_W'(1);
        end else if (!rbd_done) begin
            rbd_cnt <= rbd_cnt + 1'b1;
        end
    end

    // Sticky status: cleared only by reset or by returning to IDLE; both update
    // together with the state so they appear in the same cycle as RESYNC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_q  <= 1'b0;
            resync_cnt <= '0;
        end else if (next_state == ST_IDLE) begin
            timeout_q  <= 1'b0;
            resync_cnt <= '0;
        end else if (next_state == ST_RESYNC) begin
            if (state == ST_ILAS) timeout_q <= 1'b1;
            if (resync_cnt != '1) resync_cnt <= resync_cnt + 1'b1;
        end
    end

    assign ctrl              = decode_ctrl(state);
    assign cgs_reset_o       = ctrl.cgs_reset;
    assign ifs_reset_o       = ctrl.ifs_reset;
    assign buffer_release_no = ctrl.release_n;
    assign sync_no           = ctrl.sync_n;
    assign link_up_o         = ctrl.link_up;
    assign lmfc_o            = lmfc;
    assign timeout_o         = timeout_q;
    assign state_o           = state;
    assign resync_cnt_o      = resync_cnt;

endmodule

// File: tb/tb_jesd_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jesd_rx_link_ctrl
// Directed bench for jesd_rx_link_ctrl (MF_CYCLES=8, RBD=2, ILAS_TIMEOUT_MF=8,
// ERR_THRESH=4, CNT_W=2). The stimulus thread schedules expected output values
// against absolute cycle numbers; a monitor samples on the falling edge and
// retires every expectation that falls due.
// -----------------------------------------------------------------------------
module tb_jesd_rx_link_ctrl;

    localparam int MF   = 8;
    localparam int RBDC = 2;
    localparam int TOMF = 8;
    localparam int ERRT = 4;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          sysref;
    logic          cgs_det;
    logic          brdy_n;
    logic          char_err;
    logic          cgs_reset;
    logic          ifs_reset;
    logic          release_n;
    logic          sync_n;
    logic          lmfc;
    logic          link_up;
    logic          timeout;
    logic [2:0]    state;
    logic [CW-1:0] resync_cnt;

    jesd_rx_link_ctrl #(
        .MF_CYCLES       (MF),
        .RBD             (RBDC),
        .ILAS_TIMEOUT_MF (TOMF),
        .ERR_THRESH      (ERRT),
        .CNT_W           (CW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .enable_i          (enable),
        .sysref_i          (sysref),
        .cgs_detected_i    (cgs_det),
        .buffer_ready_ni   (brdy_n),
        .char_err_i        (char_err),
        .cgs_reset_o       (cgs_reset),
        .ifs_reset_o       (ifs_reset),
        .buffer_release_no (release_n),
        .sync_no           (sync_n),
        .lmfc_o            (lmfc),
        .link_up_o         (link_up),
        .timeout_o         (timeout),
        .state_o           (state),
        .resync_cnt_o      (resync_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {
        SIG_STATE, SIG_SYNC_N, SIG_CGS_RST, SIG_IFS_RST, SIG_REL_N,
        SIG_LMFC, SIG_LINK, SIG_TIMEOUT, SIG_RCNT
    } sig_e;

    typedef struct {
        int    cyc;
        sig_e  sig;
        int    val;
        string name;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(sig_e s);
        case (s)
            SIG_STATE:   return 32'(state);
            SIG_SYNC_N:  return 32'(sync_n);
            SIG_CGS_RST: return 32'(cgs_reset);
            SIG_IFS_RST: return 32'(ifs_reset);
            SIG_REL_N:   return 32'(release_n);
            SIG_LMFC:    return 32'(lmfc);
            SIG_LINK:    return 32'(link_up);
            SIG_TIMEOUT: return 32'(timeout);
            SIG_RCNT:    return 32'(resync_cnt);
            default:     return 32'hdead_beef;
        endcase
    endfunction

    function automatic void expect_at(int c, sig_e s, int v, string n);
        exp_t e;
        e.cyc  = c;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endfunction

    function automatic void expect_reset(int c, string n);
        expect_at(c, SIG_STATE,   0, n);
        expect_at(c, SIG_CGS_RST, 1, n);
        expect_at(c, SIG_IFS_RST, 1, n);
        expect_at(c, SIG_REL_N,   1, n);
        expect_at(c, SIG_SYNC_N,  0, n);
        expect_at(c, SIG_LMFC,    1, n);
        expect_at(c, SIG_LINK,    0, n);
        expect_at(c, SIG_TIMEOUT, 0, n);
        expect_at(c, SIG_RCNT,    0, n);
    endfunction

    // Monitor: retires due expectations on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d never sampled",
                             exp_q[i].name, exp_q[i].cyc);
                    exp_q.delete(i);
                end else if (exp_q[i].cyc == cyc) begin
                    act = sample(exp_q[i].sig);
                    checks++;
                    if (act !== 32'(exp_q[i].val)) begin
                        errors++;
                        $display("FAIL %s (%s) @cycle %0d: got %0d, expected %0d",
                                 exp_q[i].name, exp_q[i].sig.name(), cyc, act, exp_q[i].val);
                    end
                    exp_q.delete(i);
                end
            end
        end
    end

    // Drive point: 1 time unit after a rising edge; inputs set here are
    // sampled at the next edge and their effect is visible in cycle cyc+1.
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_to(int c);
        step(c - cyc);
    endtask

    task automatic err_at(int c);
        step_to(c);
        char_err = 1'b1;
        step(1);
        char_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int l0;
        int b;
        int m;
        int s;

        rst      = 1'b1;
        enable   = 1'b0;
        sysref   = 1'b0;
        cgs_det  = 1'b0;
        brdy_n   = 1'b1;
        char_err = 1'b0;

        // Reset values while reset is held.
        step(3);
        expect_reset(cyc + 1, "reset_values");
        step(2);
        rst = 1'b0;
        step(5);

        // SYSREF alignment: rising edge in cycle c -> boundary at c+1, held high.
        c      = cyc;
        l0     = c + 1;
        sysref = 1'b1;
        expect_at(l0,      SIG_LMFC, 1, "sysref_align");
        expect_at(l0 + 1,  SIG_LMFC, 0, "sysref_held_no_realign");
        expect_at(l0 + 7,  SIG_LMFC, 0, "lmfc_mid");
        expect_at(l0 + 8,  SIG_LMFC, 1, "lmfc_period_1");
        expect_at(l0 + 16, SIG_LMFC, 1, "lmfc_period_2");
        step(18);
        sysref = 1'b0;

        // Bring-up: enable -> CGS next cycle.
        c      = cyc;
        enable = 1'b1;
        expect_at(c + 1, SIG_STATE,   1, "enter_cgs");
        expect_at(c + 1, SIG_CGS_RST, 0, "cgs_reset_low");
        expect_at(c + 1, SIG_IFS_RST, 1, "cgs_ifs_reset_high");
        expect_at(c + 1, SIG_SYNC_N,  0, "cgs_sync_low");
        while (((cyc - l0) % MF) != 3) step(1);
        cgs_det = 1'b1;
        b = cyc + 5;
        expect_at(b,     SIG_LMFC,    1, "cgs_boundary");
        expect_at(b,     SIG_SYNC_N,  0, "sync_held_to_boundary");
        expect_at(b + 1, SIG_SYNC_N,  1, "sync_release");
        expect_at(b + 1, SIG_STATE,   2, "enter_ilas");
        expect_at(b + 1, SIG_IFS_RST, 0, "ilas_ifs_reset_low");
        step_to(b + 3);
        brdy_n = 1'b0;
        m = b + 8;
        expect_at(b + 4, SIG_STATE, 3, "enter_release");
        expect_at(m + 2, SIG_REL_N, 1, "release_waits_rbd");
        expect_at(m + 3, SIG_REL_N, 0, "buffer_release");
        expect_at(m + 3, SIG_LINK,  1, "link_up");
        expect_at(m + 3, SIG_STATE, 4, "enter_data");
        step_to(m + 4);
        brdy_n = 1'b1;

        // Error threshold: 3 in one MF, 3 + 1 across a boundary, then 4.
        expect_at(m + 15, SIG_STATE,   4, "err3_stays");
        expect_at(m + 17, SIG_STATE,   4, "err3_after_boundary");
        expect_at(m + 23, SIG_STATE,   4, "err3_again");
        expect_at(m + 27, SIG_STATE,   4, "err3_plus1_next_mf");
        expect_at(m + 36, SIG_STATE,   4, "err4_pending");
        expect_at(m + 37, SIG_STATE,   5, "err4_resync");
        expect_at(m + 37, SIG_SYNC_N,  0, "resync_sync_low");
        expect_at(m + 37, SIG_CGS_RST, 1, "resync_cgs_reset");
        expect_at(m + 37, SIG_LINK,    0, "resync_link_down");
        expect_at(m + 37, SIG_RCNT,    1, "resync_cnt_1");
        expect_at(m + 37, SIG_TIMEOUT, 0, "err_resync_no_timeout");
        expect_at(m + 38, SIG_STATE,   1, "resync_to_cgs");
        err_at(m + 9);
        err_at(m + 10);
        err_at(m + 11);
        err_at(m + 20);
        err_at(m + 21);
        err_at(m + 22);
        err_at(m + 25);
        err_at(m + 33);
        err_at(m + 34);
        err_at(m + 35);
        err_at(m + 36);

        // ILAS timeout: ILAS from m+41, 8th boundary inside ILAS at m+104.
        expect_at(m + 41,  SIG_STATE,   2, "reenter_ilas");
        expect_at(m + 104, SIG_STATE,   2, "ilas_before_timeout");
        expect_at(m + 104, SIG_TIMEOUT, 0, "timeout_not_yet");
        expect_at(m + 105, SIG_STATE,   5, "ilas_timeout_resync");
        expect_at(m + 105, SIG_TIMEOUT, 1, "timeout_set");
        expect_at(m + 105, SIG_RCNT,    2, "resync_cnt_2");
        expect_at(m + 105, SIG_SYNC_N,  0, "timeout_sync_low");
        expect_at(m + 106, SIG_STATE,   1, "timeout_to_cgs");
        expect_at(m + 106, SIG_TIMEOUT, 1, "timeout_sticky");

        // Back to DATA, then disable.
        step_to(m + 115);
        brdy_n = 1'b0;
        expect_at(m + 116, SIG_STATE,   3, "release_again");
        expect_at(m + 123, SIG_STATE,   4, "data_again");
        expect_at(m + 125, SIG_TIMEOUT, 1, "timeout_sticky_in_data");
        expect_at(m + 125, SIG_RCNT,    2, "resync_cnt_kept");
        step_to(m + 124);
        brdy_n = 1'b1;
        step_to(m + 125);
        enable = 1'b0;
        expect_at(m + 126, SIG_STATE,   0, "disable_idle");
        expect_at(m + 126, SIG_TIMEOUT, 0, "disable_clears_timeout");
        expect_at(m + 126, SIG_RCNT,    0, "disable_clears_resync_cnt");
        expect_at(m + 126, SIG_LINK,    0, "disable_link_down");
        expect_at(m + 126, SIG_SYNC_N,  0, "disable_sync_low");

        // Asynchronous reset in ILAS: outputs back to reset values mid-cycle.
        step_to(m + 127);
        enable = 1'b1;
        expect_at(m + 129, SIG_STATE, 2, "ilas_before_reset");
        expect_at(m + 131, SIG_STATE, 2, "ilas_still");
        expect_reset(m + 132, "async_reset_in_ilas");
        step_to(m + 132);
        rst    = 1'b1;
        enable = 1'b0;
        step(2);
        rst = 1'b0;
        step(3);

        // Saturation: continuous errors give a resync every 16 cycles.
        s        = cyc;
        sysref   = 1'b1;
        enable   = 1'b1;
        cgs_det  = 1'b1;
        brdy_n   = 1'b0;
        char_err = 1'b1;
        expect_at(s + 1,  SIG_LMFC,  1, "sat_realign");
        expect_at(s + 1,  SIG_STATE, 1, "sat_cgs");
        expect_at(s + 2,  SIG_STATE, 2, "sat_ilas");
        expect_at(s + 3,  SIG_STATE, 3, "sat_release");
        expect_at(s + 12, SIG_STATE, 4, "sat_data");
        expect_at(s + 15, SIG_STATE, 4, "sat_data_err3");
        expect_at(s + 16, SIG_STATE, 5, "sat_resync_1");
        expect_at(s + 16, SIG_RCNT,  1, "sat_cnt_1");
        expect_at(s + 32, SIG_RCNT,  2, "sat_cnt_2");
        expect_at(s + 48, SIG_RCNT,  3, "sat_cnt_3");
        expect_at(s + 64, SIG_STATE, 5, "sat_resync_4");
        expect_at(s + 64, SIG_RCNT,  3, "sat_cnt_hold_4");
        expect_at(s + 80, SIG_STATE, 5, "sat_resync_5");
        expect_at(s + 80, SIG_RCNT,  3, "sat_cnt_hold_5");
        step(1);
        sysref = 1'b0;
        step_to(s + 82);
        char_err = 1'b0;
        enable   = 1'b0;

        for (int i = 0; (i < 50) && (exp_q.size() > 0); i++) step(1);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        step(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
